// File: rtl/dm_bus_arbiter_pkg.sv
// Shared constants for the data-memory bus arbiter.
// Holds the access-mode codes (DMMode), the arbiter state encoding and the
// read-owner codes, plus a helper that classifies a request as read or write.
package dm_bus_arbiter_pkg;

    // Access mode of a data-memory request: an all-zero byte enable is a read.
    typedef enum logic {
        DM_MODE_READ  = 1'b0,
        DM_MODE_WRITE = 1'b1
    } dm_mode_e;

    // Arbiter state: normal round-robin or DMA holding the bus.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    // Requester codes, used both for the read-return owner and last grant.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    // Classify a request by its byte enables.
    function automatic dm_mode_e access_mode(input logic [3:0] byteen);
        if (byteen == 4'b0000) begin
            return DM_MODE_READ;
        end else begin
            return DM_MODE_WRITE;
        end
    endfunction

endpackage

// File: rtl/dm_bus_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the DMA engine, the arbiter and the
// single data-memory port.
//   c_*      : CPU request (c_flush squashes it), grant and read return
//   d_*      : DMA request (d_lock holds the bus), grant and read return
//   m_data_* : memory port; m_data_rdata answers the previous cycle's address
// Modport slave is the arbiter's view, master the requesters'/memory's view.
interface dm_bus_arbiter_if;
    logic        c_req;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_byteen;
    logic        c_flush;
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;

    logic        d_req;
    logic        d_lock;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteen;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;

    modport slave (
        input  c_req, c_addr, c_wdata, c_byteen, c_flush,
        input  d_req, d_lock, d_addr, d_wdata, d_byteen,
        input  m_data_rdata,
        output c_gnt, c_rvalid, c_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_data_addr, m_data_wdata, m_data_byteen
    );

    modport master (
        output c_req, c_addr, c_wdata, c_byteen, c_flush,
        output d_req, d_lock, d_addr, d_wdata, d_byteen,
        output m_data_rdata,
        input  c_gnt, c_rvalid, c_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_data_addr, m_data_wdata, m_data_byteen
    );
endinterface

// File: rtl/dm_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick.
//   req_cpu, req_dma : effective requests
//   last_gnt_dma     : 1 when DMA held the most recent grant
//   gnt_cpu, gnt_dma : one-hot (or zero) grant
// A lone requester always wins; on contention the one not granted last wins.
module dm_bus_arbiter_rr_pick2 (
    input  logic req_cpu,
    input  logic req_dma,
    input  logic last_gnt_dma,
    output logic gnt_cpu,
    output logic gnt_dma
);

    // Pick a winner from the two requests and the previous winner.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_dma = 1'b0;
        if (req_cpu && req_dma) begin
            gnt_cpu = last_gnt_dma;
            gnt_dma = ~last_gnt_dma;
        end else begin
            gnt_cpu = req_cpu;
            gnt_dma = req_dma;
        end
    end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Data-memory bus arbiter between the CPU MEM stage and a DMA engine.
//   clk   : sole clock, rising edge
//   reset : synchronous, active high
//   bus   : dm_bus_arbiter_if.slave (requests, grants, read returns, memory port)
// Grants are combinational from the current requests and registered state.
// A DMA request with d_lock enters a locked burst capped at MAX_LOCK grants
// while the CPU waits. Reads return one cycle after their grant, to the owner
// recorded in rd_owner, with no bubble between back-to-back transfers.
module dm_bus_arbiter #(
    parameter int MAX_LOCK = 8
) (
    input  logic             clk,
    input  logic             reset,
    dm_bus_arbiter_if.slave  bus
);
    import dm_bus_arbiter_pkg::*;

    localparam int               CNT_W      = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_LOCK_C = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);

    logic             c_eff_s;
    logic             d_hold_s;
    logic             cnt_at_max_s;
    logic             last_dma_s;
    logic             rr_c_s;
    logic             rr_d_s;
    logic             c_win_s;
    logic             d_win_s;
    logic             c_gnt_s;
    logic             d_gnt_s;
    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] lock_cnt_r;
    logic [CNT_W-1:0] lock_cnt_nxt_s;
    owner_e           last_gnt_r;
    owner_e           rd_owner_r;
    owner_e           rd_owner_nxt_s;

    // A flushed CPU request does not exist for arbitration.
    assign c_eff_s      = bus.c_req & ~bus.c_flush;
    assign d_hold_s     = bus.d_req & bus.d_lock;
    assign cnt_at_max_s = (lock_cnt_r == MAX_LOCK_C);
    assign last_dma_s   = (last_gnt_r == OWN_DMA);

    dm_bus_arbiter_rr_pick2 u_rr_pick2 (
        .req_cpu      (c_eff_s),
        .req_dma      (bus.d_req),
        .last_gnt_dma (last_dma_s),
        .gnt_cpu      (rr_c_s),
        .gnt_dma      (rr_d_s)
    );

    // Next-state and arbitration decision for IDLE / LOCK.
    always_comb begin
        state_nxt_s    = state_r;
        lock_cnt_nxt_s = lock_cnt_r;
        c_win_s        = 1'b0;
        d_win_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                c_win_s = rr_c_s;
                d_win_s = rr_d_s;
                if (rr_d_s && bus.d_lock) begin
                    state_nxt_s    = ST_LOCK;
                    lock_cnt_nxt_s = CNT_ONE_C;
                end else begin
                    state_nxt_s    = ST_IDLE;
                    lock_cnt_nxt_s = CNT_ZERO_C;
                end
            end
            ST_LOCK: begin
                if (d_hold_s) begin
                    if (cnt_at_max_s && c_eff_s) begin
                        // Burst cap reached with the CPU waiting: CPU gets this slot.
                        c_win_s        = 1'b1;
                        state_nxt_s    = ST_IDLE;
                        lock_cnt_nxt_s = CNT_ZERO_C;
                    end else begin
                        // Saturate so a late CPU request is served at once.
                        d_win_s        = 1'b1;
                        state_nxt_s    = ST_LOCK;
                        lock_cnt_nxt_s = cnt_at_max_s ? lock_cnt_r : (lock_cnt_r + CNT_ONE_C);
                    end
                end else begin
                    // Lock released: this cycle arbitrates as IDLE. A DMA win
                    // here cannot carry d_lock, so the lock is not re-entered.
                    c_win_s        = rr_c_s;
                    d_win_s        = rr_d_s;
                    state_nxt_s    = ST_IDLE;
                    lock_cnt_nxt_s = CNT_ZERO_C;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                lock_cnt_nxt_s = CNT_ZERO_C;
            end
        endcase
    end

    // No grant may leave the arbiter while reset is asserted.
    assign c_gnt_s   = c_win_s & ~reset;
    assign d_gnt_s   = d_win_s & ~reset;
    assign bus.c_gnt = c_gnt_s;
    assign bus.d_gnt = d_gnt_s;

    // Memory port mux: granted requester drives, otherwise idle zeros.
    always_comb begin
        bus.m_data_addr   = 32'd0;
        bus.m_data_wdata  = 32'd0;
        bus.m_data_byteen = 4'd0;
        if (c_gnt_s) begin
            bus.m_data_addr   = bus.c_addr;
            bus.m_data_wdata  = bus.c_wdata;
            bus.m_data_byteen = bus.c_byteen;
        end else if (d_gnt_s) begin
            bus.m_data_addr   = bus.d_addr;
            bus.m_data_wdata  = bus.d_wdata;
            bus.m_data_byteen = bus.d_byteen;
        end else begin
            bus.m_data_addr   = 32'd0;
            bus.m_data_wdata  = 32'd0;
            bus.m_data_byteen = 4'd0;
        end
    end

    // Who owns next cycle's read data: only a granted read claims it.
    always_comb begin
        rd_owner_nxt_s = OWN_NONE;
        if (c_gnt_s && (access_mode(bus.c_byteen) == DM_MODE_READ)) begin
            rd_owner_nxt_s = OWN_CPU;
        end else if (d_gnt_s && (access_mode(bus.d_byteen) == DM_MODE_READ)) begin
            rd_owner_nxt_s = OWN_DMA;
        end else begin
            rd_owner_nxt_s = OWN_NONE;
        end
    end

    // Read return steering; reset also masks a return still in flight.
    always_comb begin
        bus.c_rvalid = 1'b0;
        bus.c_rdata  = 32'd0;
        bus.d_rvalid = 1'b0;
        bus.d_rdata  = 32'd0;
        if (reset) begin
            bus.c_rvalid = 1'b0;
            bus.d_rvalid = 1'b0;
        end else if (rd_owner_r == OWN_CPU) begin
            bus.c_rvalid = 1'b1;
            bus.c_rdata  = bus.m_data_rdata;
        end else if (rd_owner_r == OWN_DMA) begin
            bus.d_rvalid = 1'b1;
            bus.d_rdata  = bus.m_data_rdata;
        end else begin
            bus.c_rvalid = 1'b0;
            bus.d_rvalid = 1'b0;
        end
    end

    // State, burst counter, round-robin history and read owner registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            lock_cnt_r <= CNT_ZERO_C;
            last_gnt_r <= OWN_DMA;
            rd_owner_r <= OWN_NONE;
        end else begin
            state_r    <= state_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            rd_owner_r <= rd_owner_nxt_s;
            if (c_gnt_s) begin
                last_gnt_r <= OWN_CPU;
            end else if (d_gnt_s) begin
                last_gnt_r <= OWN_DMA;
            end else begin
                last_gnt_r <= last_gnt_r;
            end
        end
    end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Self-checking bench for dm_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_dm_bus_arbiter;

    localparam int MAX_LOCK = 8;

    logic clk;
    logic reset;

    dm_bus_arbiter_if bus ();

    dm_bus_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_errors;

    // Behavioural model state.
    bit          m_locked;     // DMA currently holds a locked burst
    int          m_burst;      // DMA grants in the current locked burst
    bit          m_last_dma;   // most recent grant went to DMA
    int          m_rd_owner;   // 0 none, 1 CPU, 2 DMA
    logic [31:0] m_rd_addr;    // address of the read returning next cycle
    int          streak;       // consecutive DMA grants with the CPU pending

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEADBEEF;
        return {a[15:0], a[31:16]} ^ 32'h3C3C_C3C3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input bit cr, input bit cf, input logic [31:0] ca,
                           input logic [31:0] cw, input logic [3:0] cbe,
                           input bit dr, input bit dl, input logic [31:0] da,
                           input logic [31:0] dw, input logic [3:0] dbe);
        bus.c_req = cr;  bus.c_flush = cf; bus.c_addr = ca; bus.c_wdata = cw; bus.c_byteen = cbe;
        bus.d_req = dr;  bus.d_lock = dl;  bus.d_addr = da; bus.d_wdata = dw; bus.d_byteen = dbe;
    endtask

    // One cycle: predict, compare mid-cycle, advance the model at the edge,
    // then let the memory answer the address it saw this cycle.
    task automatic tick();
        bit          ce, eg_c, eg_d, dl, rst;
        logic [31:0] ea, ew, ca, da, cur_addr, erd_c, erd_d;
        logic [3:0]  eb, cbe, dbe;
        #4;
        rst = reset;
        ce  = bus.c_req && !bus.c_flush;
        dl  = bus.d_lock;
        ca  = bus.c_addr;   da  = bus.d_addr;
        cbe = bus.c_byteen; dbe = bus.d_byteen;
        eg_c = 1'b0;
        eg_d = 1'b0;
        if (!rst) begin
            if (m_locked && bus.d_req && bus.d_lock) begin
                if (ce && m_burst >= MAX_LOCK) eg_c = 1'b1;
                else                           eg_d = 1'b1;
            end else if (ce && bus.d_req) begin
                if (m_last_dma) eg_c = 1'b1;
                else            eg_d = 1'b1;
            end else begin
                eg_c = ce;
                eg_d = bus.d_req;
            end
        end
        ea = 32'd0; ew = 32'd0; eb = 4'd0;
        if (eg_c) begin
            ea = bus.c_addr; ew = bus.c_wdata; eb = bus.c_byteen;
        end else if (eg_d) begin
            ea = bus.d_addr; ew = bus.d_wdata; eb = bus.d_byteen;
        end
        erd_c = (!rst && m_rd_owner == 1) ? mem_f(m_rd_addr) : 32'd0;
        erd_d = (!rst && m_rd_owner == 2) ? mem_f(m_rd_addr) : 32'd0;

        check_eq("c_gnt",    32'(bus.c_gnt),         32'(eg_c));
        check_eq("d_gnt",    32'(bus.d_gnt),         32'(eg_d));
        check_eq("m_addr",   bus.m_data_addr,        ea);
        check_eq("m_wdata",  bus.m_data_wdata,       ew);
        check_eq("m_byteen", 32'(bus.m_data_byteen), 32'(eb));
        check_eq("c_rvalid", 32'(bus.c_rvalid),      32'(!rst && m_rd_owner == 1));
        check_eq("d_rvalid", 32'(bus.d_rvalid),      32'(!rst && m_rd_owner == 2));
        check_eq("c_rdata",  bus.c_rdata,            erd_c);
        check_eq("d_rdata",  bus.d_rdata,            erd_d);

        // Independent fairness bound on the observed grants.
        if (!rst && ce && bus.d_gnt) streak++;
        else                         streak = 0;
        check_eq("lock_bound", 32'(streak <= MAX_LOCK), 32'd1);

        cur_addr = bus.m_data_addr;
        @(posedge clk);
        if (rst) begin
            m_locked   = 1'b0;
            m_burst    = 0;
            m_last_dma = 1'b1;
            m_rd_owner = 0;
        end else begin
            if (eg_d && dl) begin
                m_burst  = m_locked ? m_burst + 1 : 1;
                m_locked = 1'b1;
            end else begin
                m_locked = 1'b0;
                m_burst  = 0;
            end
            if (eg_c)      m_last_dma = 1'b0;
            else if (eg_d) m_last_dma = 1'b1;
            if (eg_c && cbe == 4'd0) begin
                m_rd_owner = 1; m_rd_addr = ca;
            end else if (eg_d && dbe == 4'd0) begin
                m_rd_owner = 2; m_rd_addr = da;
            end else begin
                m_rd_owner = 0;
            end
        end
        #1;
        bus.m_data_rdata = mem_f(cur_addr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        m_locked   = 1'b0;
        m_burst    = 0;
        m_last_dma = 1'b1;
        m_rd_owner = 0;
        m_rd_addr  = 32'd0;
        streak     = 0;
        reset      = 1'b1;
        bus.m_data_rdata = 32'd0;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(posedge clk);
        #1;

        // Reset with both requesters active: everything held quiet.
        set_req(1'b1, 1'b0, 32'h40, 32'h11, 4'hF, 1'b1, 1'b1, 32'h80, 32'h22, 4'h0);
        tick();
        tick();
        reset = 1'b0;

        // Lone CPU read of 0x100, data returns the next cycle.
        set_req(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Contention straight after reset alternates CPU, DMA, CPU, DMA.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'h0,
                    1'b1, 1'b0, 32'h2000 + 32'(i * 4), 32'h0, 4'h0);
            tick();
        end

        // Locked DMA burst with the CPU waiting: capped at MAX_LOCK.
        do_reset();
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h3000, 32'h5, 4'h0);
        tick();
        for (int i = 1; i < 14; i++) begin
            set_req(1'b1, 1'b0, 32'h4000 + 32'(i * 4), 32'h0, 4'h0,
                    1'b1, 1'b1, 32'h3000 + 32'(i * 4), 32'(i), (i % 2 == 0) ? 4'h0 : 4'h3);
            tick();
        end
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Flushed CPU write: no grant, no memory write; DMA unaffected.
        set_req(1'b1, 1'b1, 32'h500, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        set_req(1'b1, 1'b1, 32'h504, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 32'h600, 32'h9, 4'h1);
        tick();

        // Reset right after a locked DMA read grant: no return, back to IDLE.
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h700, 32'h0, 4'h0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(1'b1, 1'b0, 32'h800, 32'h0, 4'h0, 1'b1, 1'b1, 32'h704, 32'h0, 4'h0);
        tick();
        tick();

        // Randomized traffic with occasional resets and flushes.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            set_req($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                    ($urandom_range(0, 9) == 0) ? 32'h100 : $urandom, $urandom,
                    ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                    $urandom, $urandom,
                    ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
            tick();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dm_bus_arbiter.md
DM_BUS_ARBITER -- requirements
Module: dm_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_LOCK, default 8, max consecutive DMA grants in a locked burst while CPU waits.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports c_req in 1, c_addr in 32, c_wdata in 32, c_byteen in 4: CPU MEM-stage request; c_byteen==0 means read.
REQ-005 SHALL have port c_flush  in  1  exception/interrupt squash of the CPU request in the current cycle.
REQ-006 SHALL have ports c_gnt out 1, c_rvalid out 1, c_rdata out 32: CPU grant, read-return strobe, read data.
REQ-007 SHALL have ports d_req in 1, d_lock in 1, d_addr in 32, d_wdata in 32, d_byteen in 4: DMA request; d_lock asks to hold the bus.
REQ-008 SHALL have ports d_gnt out 1, d_rvalid out 1, d_rdata out 32: DMA grant, read-return strobe, read data.
REQ-009 SHALL have ports m_data_addr out 32, m_data_wdata out 32, m_data_byteen out 4, m_data_rdata in 32: single data-memory port; rdata valid exactly one cycle after address.

Function
REQ-010 SHALL assert at most one of c_gnt/d_gnt per cycle; grants combinational from current requests and registered state.
REQ-011 SHALL treat c_req as 0 in any cycle with c_flush=1 (no c_gnt, no memory write from CPU).
REQ-012 SHALL, in state IDLE with one effective requester, grant that requester.
REQ-013 SHALL, in IDLE with both requesting, grant the one not in register last_gnt (round robin); last_gnt updates on every grant.
REQ-014 SHALL enter state LOCK when DMA is granted with d_lock=1; lock_cnt loads 1.
REQ-015 SHALL, in LOCK, grant DMA exclusively while d_req&d_lock, incrementing lock_cnt per DMA grant.
REQ-016 SHALL leave LOCK to IDLE when d_req or d_lock is 0 (that cycle arbitrates as IDLE), or when lock_cnt==MAX_LOCK and c_req effective, in which case CPU is granted that cycle.
REQ-017 SHALL never exceed MAX_LOCK consecutive DMA grants while an effective c_req is pending.
REQ-018 SHALL drive m_data_addr/wdata/byteen from the granted requester; with no grant drive addr 0, wdata 0, byteen 0.
REQ-019 SHALL register rd_owner (NONE/CPU/DMA) on a granted read; writes set NONE.
REQ-020 SHALL, one cycle after a granted read, pulse the owner's rvalid for exactly one cycle with its rdata = m_data_rdata; non-owner rdata 0.
REQ-021 SHALL issue no rvalid for writes; back-to-back reads return in grant order, one per cycle.
REQ-022 SHALL let a new grant proceed in the same cycle a previous read returns (full throughput, no bubble).

Reset
REQ-023 SHALL on reset set state IDLE, lock_cnt 0, last_gnt DMA (CPU wins first contention), rd_owner NONE.
REQ-024 SHALL hold all grants and m_data_byteen at 0 during reset and suppress any rvalid in the cycle after reset.

Structure
REQ-025 SHALL place state encoding (IDLE, LOCK) and owner codes (NONE, CPU, DMA) as constants in the shared defines header beside the DMMode codes.
REQ-026 SHALL be one module; round-robin pick may be a sub-module rr_pick2 (two reqs, last_gnt -> one-hot grant).

Verification
REQ-027 SHALL cover: c_req read addr 0x100 alone, rdata 0xDEADBEEF next cycle -> c_gnt=1 same cycle, c_rvalid=1 with c_rdata=0xDEADBEEF one cycle later.
REQ-028 SHALL cover: both request after reset for 4 cycles -> grants CPU,DMA,CPU,DMA.
REQ-029 SHALL cover: d_lock burst of 12 with c_req held, MAX_LOCK=8 -> 8 d_gnt, then 1 c_gnt, then DMA resumes.
REQ-030 SHALL cover: c_req write byteen 4'b1111 with c_flush=1 -> c_gnt=0, m_data_byteen=0.
REQ-031 SHALL cover: reset asserted the cycle after a DMA read grant -> d_rvalid stays 0, state IDLE.
